// File: rtl/surfboard_stream_if.sv
// Streaming handshake bundle for the 2x2 matrix-product engine: operand words in, result words out.
interface surfboard_stream_if #(
  parameter int W = 16
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/surfboard_stream.sv
// Serial 2x2 matrix multiplier: loads A then B (row-major), computes one C element per cycle,
// then drains C[0..3] under out_valid/out_ready with out_last on C[3]. Arithmetic wraps mod 2^W.
module surfboard_stream #(
  parameter int W      = 16,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  surfboard_stream_if.slave bus,
  output logic             busy_o
);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  state_t       state_q, state_d;
  logic [2:0]   wcnt_q, wcnt_d;
  logic [1:0]   cidx_q, cidx_d;
  logic [1:0]   didx_q, didx_d;
  logic         ovld_q, ovld_d;
  logic         olast_q, olast_d;
  logic [W-1:0] odata_q, odata_d;
  logic         op_we, res_we;

  // Operand and result storage carry no reset; they are only exposed after a full COMPUTE.
  logic [W-1:0] op_q  [8];
  logic [W-1:0] res_q [4];

  function automatic logic [W-1:0] mul_wrap(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] ax, bx;
    ax = (SIGNED != 0) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = (SIGNED != 0) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return W'(ax * bx);
  endfunction

  function automatic logic [W-1:0] add_wrap(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'(a + b);
  endfunction

  logic         accept;
  logic [W-1:0] c_elem;
  logic [1:0]   dnext;

  assign bus.in_ready  = (state_q == LOAD) && !rst;
  assign bus.out_valid = ovld_q;
  assign bus.out_last  = olast_q;
  assign bus.out_data  = odata_q;
  assign busy_o        = (state_q != LOAD) || (wcnt_q != 3'd0);

  assign accept = bus.in_valid && bus.in_ready;
  assign dnext  = didx_q + 2'd1;

  // C[r][c] = A[r][0]*B[0][c] + A[r][1]*B[1][c], with r = cidx[1], c = cidx[0]
  assign c_elem = add_wrap(mul_wrap(op_q[{1'b0, cidx_q[1], 1'b0}], op_q[{2'b10, cidx_q[0]}]),
                           mul_wrap(op_q[{1'b0, cidx_q[1], 1'b1}], op_q[{2'b11, cidx_q[0]}]));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cidx_d  = cidx_q;
    didx_d  = didx_q;
    ovld_d  = ovld_q;
    olast_d = olast_q;
    odata_d = odata_q;
    op_we   = 1'b0;
    res_we  = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          op_we = 1'b1;
          if (wcnt_q == 3'd7) begin
            wcnt_d  = 3'd0;
            cidx_d  = 2'd0;
            state_d = COMPUTE;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      COMPUTE: begin
        res_we = 1'b1;
        cidx_d = cidx_q + 2'd1;
        if (cidx_q == 2'd3) begin
          didx_d  = 2'd0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // First DRAIN cycle registers C[0] into the output stage.
        if (!ovld_q) begin
          ovld_d  = 1'b1;
          odata_d = res_q[0];
          olast_d = 1'b0;
          didx_d  = 2'd0;
        end else if (bus.out_ready) begin
          if (didx_q == 2'd3) begin
            ovld_d  = 1'b0;
            olast_d = 1'b0;
            odata_d = '0;
            state_d = LOAD;
          end else begin
            didx_d  = dnext;
            odata_d = res_q[dnext];
            olast_d = (dnext == 2'd3);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      wcnt_q  <= 3'd0;
      cidx_q  <= 2'd0;
      didx_q  <= 2'd0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cidx_q  <= cidx_d;
      didx_q  <= didx_d;
      ovld_q  <= ovld_d;
      olast_q <= olast_d;
      odata_q <= odata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (op_we)  op_q[wcnt_q]  <= bus.in_data;
    if (res_we) res_q[cidx_q] <= c_elem;
  end

endmodule

// File: tb/tb_surfboard_stream.sv
// Directed bench for surfboard_stream: hand-computed 2x2 products, latency, backpressure and resets.
module tb_surfboard_stream;

  logic clk;
  logic rst;
  logic busy;
  int   n_cmp;
  int   n_err;

  surfboard_stream_if #(.W(16)) bus ();

  surfboard_stream #(.W(16), .SIGNED(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input logic [15:0] v[8], input bit gap, input string nm);
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      check($sformatf("%s_in_ready_w%0d", nm, i), {31'd0, bus.in_ready}, 32'd1);
      step();
      if (gap && i < 7) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
        step();
      end
    end
    // Junk offered while not in LOAD must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
  endtask

  task automatic wait_latency(input string nm);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      check($sformatf("%s_in_ready_busy", nm), {31'd0, bus.in_ready}, 32'd0);
      step();
      lat++;
    end
    check($sformatf("%s_latency", nm), lat, 32'd5);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input logic [15:0] e[4], input bit bp, input string nm);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_valid_c%0d", nm, k), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("%s_data_c%0d", nm, k), {16'd0, bus.out_data}, {16'd0, e[k]});
      check($sformatf("%s_last_c%0d", nm, k), {31'd0, bus.out_last}, {31'd0, (k == 3)});
      if (bp) begin
        bus.out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          step();
          check($sformatf("%s_hold_data_c%0d_%0d", nm, k, h), {16'd0, bus.out_data}, {16'd0, e[k]});
          check($sformatf("%s_hold_last_c%0d_%0d", nm, k, h), {31'd0, bus.out_last}, {31'd0, (k == 3)});
          check($sformatf("%s_hold_in_ready_c%0d_%0d", nm, k, h), {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
      end
      step();
    end
    check($sformatf("%s_done_valid", nm), {31'd0, bus.out_valid}, 32'd0);
    check($sformatf("%s_done_in_ready", nm), {31'd0, bus.in_ready}, 32'd1);
    check($sformatf("%s_done_busy", nm), {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input logic [15:0] v[8], input logic [15:0] e[4], input bit bp,
                     input bit gap, input string nm);
    bus.out_ready = !bp;
    load_words(v, gap, nm);
    wait_latency(nm);
    drain(e, bp, nm);
    bus.out_ready = 1'b0;
  endtask

  logic [15:0] va[8];
  logic [15:0] ea[4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_out_last", {31'd0, bus.out_last}, 32'd0);
    check("reset_out_data", {16'd0, bus.out_data}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    #11 rst = 1'b0;
    step();
    check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Basic product
    va = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    ea = '{16'd19, 16'd22, 16'd43, 16'd50};
    run(va, ea, 1'b0, 1'b0, "basic");

    // Signed operands
    va = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'd2, 16'd3, 16'd4, 16'd5};
    ea = '{16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB};
    run(va, ea, 1'b0, 1'b0, "signed");

    // Wrap with backpressure on every word
    va = '{16'h7FFF, 16'd1, 16'd2, 16'd3, 16'd2, 16'h7FFF, 16'd1, 16'd1};
    ea = '{16'hFFFF, 16'h0002, 16'h0007, 16'h0001};
    run(va, ea, 1'b1, 1'b0, "wrap_bp");

    // Reset mid-load after 5 words, asynchronous and away from the edge
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd9;
      step();
    end
    bus.in_valid = 1'b0;
    check("midload_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midload_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("midload_rst_busy", {31'd0, busy}, 32'd0);
    #3 rst = 1'b0;
    step();
    check("midload_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    va = '{16'd2, 16'd0, 16'd0, 16'd2, 16'd3, 16'd1, 16'd4, 16'd1};
    ea = '{16'd6, 16'd2, 16'd8, 16'd2};
    run(va, ea, 1'b0, 1'b1, "fresh");

    // Reset while draining
    va = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    bus.out_ready = 1'b0;
    load_words(va, 1'b0, "drainrst");
    wait_latency("drainrst");
    check("drainrst_pre_data", {16'd0, bus.out_data}, 32'd19);
    #2 rst = 1'b1;
    #1;
    check("drainrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("drainrst_out_data", {16'd0, bus.out_data}, 32'd0);
    check("drainrst_out_last", {31'd0, bus.out_last}, 32'd0);
    #3 rst = 1'b0;
    step();

    // Wrap to zero
    va = '{16'h0100, 16'd0, 16'd0, 16'd0, 16'h0100, 16'd0, 16'd0, 16'd0};
    ea = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run(va, ea, 1'b0, 1'b0, "wrap0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/surfboard_stream.md
SURFBOARD_STREAM -- requirements
Module: surfboard_stream

Interface
REQ-001 Parameter W, default 16, element width in bits.
REQ-002 Parameter SIGNED, default 1, operand interpretation (1 = two's complement, 0 = unsigned).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_data  input  W  serial operand word.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 out_data  output  W  serial result word.
REQ-009 out_valid  output  1  out_data valid this cycle.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_last  output  1  marks the 4th (final) result word of a product.
REQ-012 busy  output  1  high in any state other than LOAD, or in LOAD with at least 1 word held.

Function
REQ-013 Block SHALL compute the 2x2 matrix product C = A x B, all matrices row-major (index 0..3 = r0c0, r0c1, r1c0, r1c1).
REQ-014 Input handshake: word accepted on a cycle with in_valid && in_ready; in_data ignored otherwise.
REQ-015 Input order SHALL be A[0], A[1], A[2], A[3], B[0], B[1], B[2], B[3] (8 words).
REQ-016 Output order SHALL be C[0], C[1], C[2], C[3]; out_last high only with C[3].
REQ-017 C[0]=A0*B0+A1*B2; C[1]=A0*B1+A1*B3; C[2]=A2*B0+A3*B2; C[3]=A2*B1+A3*B3.
REQ-018 Products use SIGNED interpretation; each product and sum SHALL be truncated to the low W bits (wrap mod 2^W), no saturation, no overflow flag.
REQ-019 FSM states: LOAD, COMPUTE, DRAIN.
REQ-020 LOAD: in_ready=1, out_valid=0; 3-bit word counter increments per accepted word; on acceptance of the 8th word -> COMPUTE next cycle, counter cleared.
REQ-021 COMPUTE: in_ready=0; one C element computed and registered per cycle (C[0]..C[3]), exactly 4 cycles, then -> DRAIN.
REQ-022 Latency: out_valid SHALL first assert 5 cycles after the clock edge that accepts the 8th word.
REQ-023 DRAIN: out_valid=1, in_ready=0; out_data/out_last advance only on out_valid && out_ready.
REQ-024 While out_valid && !out_ready, out_data and out_last SHALL remain stable.
REQ-025 Handshake of C[3] SHALL return FSM to LOAD on the next cycle with in_ready=1; no overlap of load and drain.
REQ-026 out_ready asserted outside DRAIN SHALL have no effect; in_valid outside LOAD SHALL have no effect (word not consumed).
REQ-027 Operand and result registers SHALL not change except by accepted input words (LOAD) or COMPUTE writes.

Reset
REQ-028 rst SHALL immediately force: state=LOAD, word counter=0, result index=0, out_valid=0, out_last=0, out_data=0, busy=0.
REQ-029 in_ready SHALL be 0 while rst is high and 1 on the first cycle after release.
REQ-030 Reset during LOAD, COMPUTE or DRAIN SHALL discard all partial operands/results; next transfer begins at A[0].
REQ-031 Operand/result storage need not be cleared by rst but SHALL never be visible on out_data before a full COMPUTE.

Verification
REQ-032 W=16, SIGNED=1: A=1,2,3,4; B=5,6,7,8, out_ready=1 -> out_data 19,22,43,50, out_last on 50, out_valid rising 5 cycles after 8th acceptance.
REQ-033 Signed: A=-1,0,0,-1; B=2,3,4,5 -> 0xFFFE,0xFFFD,0xFFFC,0xFFFB.
REQ-034 Wrap: A=0x0100,0,0,0; B=0x0100,0,0,0 -> C[0]=0x0000, others 0; SIGNED=0 build gives identical bits.
REQ-035 Backpressure: out_ready low 3 cycles on each word -> each word held stable, all 4 delivered once, in_ready stays 0 until after C[3] handshake.
REQ-036 Reset mid-load: 5 words accepted, rst pulsed (asynchronous, off-edge), then 8 fresh words -> results match the fresh words only; in_valid gaps during load tolerated.
